ccff_chain_loader: RTL and testbench

Configuration-chain loader for the FPGA fabric's shift-register configuration path (ccff_head → ccff_tail through every tile, including the IO tiles). It accepts the bitstream as parallel words over a valid/ready stream and serialises them onto ccff_head one bit per prog_clk cycle. It produces a shift enable for the external prog_clk gate, counts exactly CHAIN_LEN shifts and reports completion. An optional second pass verifies the chain by comparing ccff_tail against the re-sent bitstream.

---
 rtl/ccff_ctrl_pkg.sv | 16 +
 rtl/ccff_word_serializer.sv | 76 +++++++
 rtl/ccff_chain_loader.sv | 102 ++++++++++
 tb/tb_ccff_chain_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_ctrl_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } ccff_state_t;

  // Counter width able to hold the value n itself (0..n).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: hold register, bit count, s_ready and head/shift_en.
// Tracks how many bits of the current pass have been committed to the hold
// register so that the final partial word only loads the bits still needed.
module ccff_word_serializer
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              clear,
  input  logic              active,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam int HW = cnt_width(WORD_W);

  logic [WORD_W-1:0] hold, hold_n;
  logic [HW-1:0]     hcnt, hcnt_n, load_cnt;
  logic [CW-1:0]     ccnt, ccnt_n, rem;
  logic              shift_en_n;
  logic              accept;

  assign rem      = CW'(CHAIN_LEN) - ccnt;
  assign load_cnt = (int'(rem) > WORD_W) ? HW'(WORD_W) : HW'(rem);

  // hcnt==1 always coincides with a shift, since shift_en mirrors hcnt!=0
  assign s_ready   = active && ((hcnt == '0) || (hcnt == HW'(1))) && (rem != '0);
  assign accept    = s_valid && s_ready;
  assign ccff_head = hold[0];

  // Next hold/count values: shift out one bit, refill on acceptance
  always_comb begin
    hold_n = hold;
    hcnt_n = hcnt;
    ccnt_n = ccnt;
    if (clear) begin
      hold_n = '0;
      hcnt_n = '0;
      ccnt_n = '0;
    end else begin
      if (ccff_shift_en) begin
        hold_n = hold >> 1;
        hcnt_n = hcnt - HW'(1);
      end
      if (accept) begin
        hold_n = s_data;
        hcnt_n = load_cnt;
        ccnt_n = ccnt + CW'(load_cnt);
      end
    end
    shift_en_n = (hcnt_n != '0);
  end

  // Serializer state registers
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      hold          <= '0;
      hcnt          <= '0;
      ccnt          <= '0;
      ccff_shift_en <= 1'b0;
    end else begin
      hold          <= hold_n;
      hcnt          <= hcnt_n;
      ccnt          <= ccnt_n;
      ccff_shift_en <= shift_en_n;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader top: FSM, pass counter and readback check.
// Optional readback verify pass is enabled by defining CCFF_READBACK_EN.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = cnt_width(CHAIN_LEN);

  ccff_state_t   state, state_n;
  logic [CW-1:0] pcnt;
  logic          active, launch, pass_end, clear;

  assign active   = (state == LOAD) || (state == VERIFY);
  assign launch   = start && !abort && ((state == IDLE) || (state == DONE));
  assign pass_end = active && ccff_shift_en && (pcnt == CW'(CHAIN_LEN - 1));
  assign clear    = abort || launch || pass_end;
  assign busy     = active;
  assign done     = (state == DONE);

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_serializer (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .clear         (clear),
    .active        (active),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en)
  );

  // State register
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) state <= IDLE;
    else           state <= state_n;
  end

  // Next-state logic; abort wins over everything
  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_n = LOAD;
`ifdef CCFF_READBACK_EN
        LOAD:    if (pass_end) state_n = VERIFY;
`else
        LOAD:    if (pass_end) state_n = DONE;
`endif
        VERIFY:  if (pass_end) state_n = DONE;
        DONE:    if (start) state_n = LOAD;
        default: state_n = IDLE;
      endcase
    end
  end

  // Pass counter: counts chain shifts, restarted at every pass boundary
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n)                    pcnt <= '0;
    else if (clear)                   pcnt <= '0;
    else if (active && ccff_shift_en) pcnt <= pcnt + CW'(1);
  end

`ifdef CCFF_READBACK_EN
  // Sticky verify error: tail carries the previous pass bit being replaced
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      err <= 1'b0;
    end else if (launch) begin
      err <= 1'b0;
    end else if ((state == VERIFY) && ccff_shift_en && (ccff_tail != ccff_head)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader with a behavioural chain model.
module tb_ccff_chain_loader;

  localparam int L = 10;
  localparam int W = 8;
`ifdef CCFF_READBACK_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif

  logic         prog_clk = 1'b0;
  logic         pReset_n = 1'b0;
  logic         start    = 1'b0;
  logic         abort    = 1'b0;
  logic [W-1:0] s_data   = '0;
  logic         s_valid  = 1'b0;
  logic         s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] word_q[$];
  logic         obs_q[$];
  logic [L-1:0] chain = '0;
  int           stuck_pos = -1;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .abort         (abort),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // Physical configuration chain: shifts head in whenever the gate is enabled
  assign ccff_tail = chain[L-1];
  always @(posedge prog_clk) begin : chain_shift
    logic [L-1:0] nxt;
    if (ccff_shift_en) begin
      nxt = {chain[L-2:0], ccff_head};
      if (stuck_pos >= 0) nxt[stuck_pos] = 1'b0;
      chain <= nxt;
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bit k of the bitstream, LSB of each word first
  function automatic int expBit(input int k);
    logic [W-1:0] w;
    w = word_q[k / W];
    return int'(w[k % W]);
  endfunction

  // One full load (P passes of the same stream); returns cycles from start to done
  task automatic applyStimulus(input int rnd_gap_pct, input int hold_len, output int cycles);
    int nwords, total, widx, skips, nshift, last_shift, done_at;
    nwords = word_q.size();
    total = nwords * P;
    widx = 0; skips = 0; nshift = 0; last_shift = -1; done_at = -1;
    obs_q.delete();
    @(negedge prog_clk);
    start = 1'b1;
    s_valid = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge prog_clk);
      start = 1'b0;
      s_valid = 1'b0;
      #1;
      if (cyc == 1) begin
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("err_cleared_on_start", int'(err), 0);
      end
      if (done) begin
        done_at = cyc;
        break;
      end
      if (ccff_shift_en) begin
        obs_q.push_back(ccff_head);
        nshift++;
        last_shift = cyc;
      end
      if (widx < total) begin
        if (widx == 1 && skips < hold_len) begin
          if (s_ready) skips++;
        end else if ($urandom_range(0, 99) >= rnd_gap_pct) begin
          s_valid = 1'b1;
        end
      end
      s_data = s_valid ? word_q[widx % nwords] : W'($urandom);
      if (s_valid && s_ready) widx++;
    end
    s_valid = 1'b0;
    cycles = done_at;
    checkOutput("done_reached", int'(done_at > 0), 1);
    checkOutput("shift_count", nshift, P * L);
    checkOutput("done_after_last_shift", done_at, last_shift + 1);
    checkOutput("words_accepted", widx, total);
    checkOutput("done_shift_en_low", int'(ccff_shift_en), 0);
    checkOutput("done_ready_low", int'(s_ready), 0);
    checkOutput("done_busy_low", int'(busy), 0);
    for (int k = 0; k < obs_q.size() && k < P * L; k++)
      checkOutput($sformatf("head_bit%0d", k), int'(obs_q[k]), expBit(k % L));
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int c1, c2, nsh;
    int exp_seq[10] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1};

    repeat (2) @(negedge prog_clk);
    checkOutput("rst_ready", int'(s_ready), 0);
    checkOutput("rst_head", int'(ccff_head), 0);
    checkOutput("rst_shift_en", int'(ccff_shift_en), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    pReset_n = 1'b1;

    // Directed stream, valid held high
    word_q = '{8'hA5, 8'h03};
    applyStimulus(0, 0, c1);
    for (int k = 0; k < 10; k++)
      checkOutput($sformatf("seq_bit%0d", k), int'(obs_q[k]), exp_seq[k]);
    checkOutput("min_load_cycles", c1, P * (L + 1) + 1);
    checkOutput("err_clean_load", int'(err), 0);

    // Same stream with valid withheld for 3 ready cycles between words
    applyStimulus(0, 3, c2);
    checkOutput("gap_load_cycles", c2, c1 + 3);

    // Abort and start together from DONE: abort wins
    @(negedge prog_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    #1;
    checkOutput("abort_priority_busy", int'(busy), 0);
    checkOutput("abort_priority_done", int'(done), 0);

    // Abort after 4 shifts
    @(negedge prog_clk);
    start = 1'b1;
    nsh = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge prog_clk);
      start = 1'b0;
      #1;
      if (nsh == 4) begin
        abort = 1'b1;
        break;
      end
      if (ccff_shift_en) nsh++;
      s_valid = 1'b1;
      s_data = word_q[0];
    end
    s_valid = 1'b0;
    checkOutput("abort_reached", nsh, 4);
    @(negedge prog_clk);
    abort = 1'b0;
    #1;
    checkOutput("abort_shift_en", int'(ccff_shift_en), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_ready", int'(s_ready), 0);
    checkOutput("abort_head", int'(ccff_head), 0);

    word_q = '{W'($urandom), W'($urandom)};
    applyStimulus(0, 0, c2);

    // Asynchronous reset mid-load
    @(negedge prog_clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge prog_clk);
      start = 1'b0;
      s_valid = 1'b1;
      s_data = 8'hFF;
    end
    #1;
    checkOutput("midload_busy", int'(busy), 1);
    pReset_n = 1'b0;
    #1;
    checkOutput("arst_ready", int'(s_ready), 0);
    checkOutput("arst_head", int'(ccff_head), 0);
    checkOutput("arst_shift_en", int'(ccff_shift_en), 0);
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_done", int'(done), 0);
    checkOutput("arst_err", int'(err), 0);
    s_valid = 1'b0;
    @(negedge prog_clk);
    pReset_n = 1'b1;

    // Randomized loads with random valid gaps
    for (int it = 0; it < 6; it++) begin
      word_q = '{W'($urandom), W'($urandom)};
      applyStimulus($urandom_range(0, 60), 0, c2);
      checkOutput("rand_err", int'(err), 0);
    end

`ifdef CCFF_READBACK_EN
    // Stuck-at-0 cell: every pass-1 bit that is 1 comes back as 0 at the tail
    begin : stuck_test
      int exp_err;
      stuck_pos = 4;
      word_q = '{8'hA5, 8'h03};
      exp_err = 0;
      for (int k = 0; k < L; k++) if (expBit(k) != 0) exp_err = 1;
      applyStimulus(0, 0, c2);
      checkOutput("stuck_err", int'(err), exp_err);
      repeat (3) @(negedge prog_clk);
      checkOutput("stuck_err_held", int'(err), exp_err);
      stuck_pos = -1;
      applyStimulus(0, 0, c2);
      checkOutput("healthy_err", int'(err), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
